// File: rtl/sfp_pkg.sv
// Shared types and helpers for the signed fixed-point requantiser.
package sfp_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC,
    RND_HALF_UP,
    RND_HALF_EVEN,
    RND_TO_ZERO
  } round_mode_e;

  // Largest positive two's-complement code of the given width, in the low bits.
  function automatic logic [31:0] sfp_max(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Most negative two's-complement code of the given width, in the low bits.
  function automatic logic [31:0] sfp_min(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sfp_round_lane.sv
// One lane of the requantiser: align + round (feeds stage 1) and
// range check + clamp/wrap (fed by stage 1, feeds stage 2).
module sfp_round_lane
  import sfp_pkg::*;
#(
  parameter int IW_IN  = 8,
  parameter int QW_IN  = 8,
  parameter int IW_OUT = 4,
  parameter int QW_OUT = 4
) (
  input  logic [IW_IN+QW_IN-1:0]   din,
  input  logic [1:0]               round_mode,
  output logic [IW_IN+QW_OUT:0]    mid,
  input  logic [IW_IN+QW_OUT:0]    mid_q,
  input  logic                     sat_en,
  output logic [IW_OUT+QW_OUT-1:0] res,
  output logic                     ovf
);

  localparam int WL_IN  = IW_IN + QW_IN;
  localparam int WL_OUT = IW_OUT + QW_OUT;
  localparam int KW     = IW_IN + QW_OUT;
  localparam int MW     = KW + 1;
  localparam int SH     = QW_IN - QW_OUT;
  localparam int TW     = MW - WL_OUT + 1;
  localparam logic [WL_OUT-1:0] MAXC = WL_OUT'(sfp_max(WL_OUT));
  localparam logic [WL_OUT-1:0] MINC = WL_OUT'(sfp_min(WL_OUT));

  generate
    if (SH > 0) begin : g_rnd
      localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);
      logic [KW-1:0] kept;
      logic [SH-1:0] rem;
      logic          inc;

      assign kept = din[WL_IN-1:SH];
      assign rem  = din[SH-1:0];

      // Every mode is expressed as floor plus a 0/1 increment.
      always_comb begin
        inc = 1'b0;
        case (round_mode)
          RND_TRUNC:     inc = 1'b0;
          RND_HALF_UP:   inc = (rem >= HALF);
          RND_HALF_EVEN: inc = (rem > HALF) || ((rem == HALF) && kept[0]);
          RND_TO_ZERO:   inc = din[WL_IN-1] && (rem != '0);
        endcase
      end

      // The extra top bit keeps a rounding carry from wrapping.
      assign mid = {kept[KW-1], kept} + MW'(inc);
    end else begin : g_shl
      logic unused_round_mode;
      assign unused_round_mode = ^round_mode;
      assign mid = {{(MW-WL_IN){din[WL_IN-1]}}, din} << (-SH);
    end
  endgenerate

  logic [TW-1:0] top;
  assign top = mid_q[MW-1:WL_OUT-1];

  // In range only when all bits above the output sign agree with it.
  always_comb begin
    ovf = !((&top) || !(|top));
    res = mid_q[WL_OUT-1:0];
    if (ovf && sat_en) res = mid_q[MW-1] ? MINC : MAXC;
  end

endmodule

// File: rtl/sfp_requant.sv
// Multi-lane two-stage requantiser with valid/ready on both sides and a
// sticky saturating count of overflowed lanes.
module sfp_requant
  import sfp_pkg::*;
#(
  parameter int IW_IN  = 8,
  parameter int QW_IN  = 8,
  parameter int IW_OUT = 4,
  parameter int QW_OUT = 4,
  parameter int LANES  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*(IW_IN+QW_IN)-1:0]    in_val,
  input  logic [1:0]                        round_mode,
  input  logic                              sat_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*(IW_OUT+QW_OUT)-1:0]  out_val,
  output logic [LANES-1:0]                  out_sat,
  output logic [CNT_W-1:0]                  sat_cnt,
  input  logic                              cnt_clr
);

  localparam int WL_IN  = IW_IN + QW_IN;
  localparam int WL_OUT = IW_OUT + QW_OUT;
  localparam int MW     = IW_IN + QW_OUT + 1;
  localparam int PW     = $clog2(LANES + 1);

  logic                      s1_valid;
  logic                      s1_sat_en;
  logic [LANES*MW-1:0]       s1_mid;
  logic [LANES*MW-1:0]       mid_c;
  logic [LANES*WL_OUT-1:0]   res_c;
  logic [LANES-1:0]          ovf_c;
  logic                      s2_load;
  logic                      s1_moves;
  logic                      in_fire;
  logic                      out_fire;
  logic [PW-1:0]             pop;
  logic [CNT_W:0]            cnt_sum;

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      sfp_round_lane #(
        .IW_IN (IW_IN),
        .QW_IN (QW_IN),
        .IW_OUT(IW_OUT),
        .QW_OUT(QW_OUT)
      ) u_lane (
        .din       (in_val[l*WL_IN +: WL_IN]),
        .round_mode(round_mode),
        .mid       (mid_c[l*MW +: MW]),
        .mid_q     (s1_mid[l*MW +: MW]),
        .sat_en    (s1_sat_en),
        .res       (res_c[l*WL_OUT +: WL_OUT]),
        .ovf       (ovf_c[l])
      );
    end
  endgenerate

  assign s2_load  = !out_valid || out_ready;
  assign s1_moves = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_moves;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Stage 1: aligned and rounded values plus the beat's overflow policy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sat_en <= 1'b0;
      s1_mid    <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_mid    <= mid_c;
        s1_sat_en <= sat_en;
      end
    end
  end

  // Stage 2: final codes and overflow flags; held while stalled downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_val   <= '0;
      out_sat   <= '0;
    end else begin
      if (s2_load) out_valid <= s1_valid;
      if (s1_moves) begin
        out_val <= res_c;
        out_sat <= ovf_c;
      end
    end
  end

  // Number of overflowed lanes in the beat leaving now, and the widened sum.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(out_sat[i]);
    cnt_sum = {1'b0, sat_cnt} + (CNT_W+1)'(pop);
  end

  // Saturating event counter; clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_fire) begin
      sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule
